// File: rtl/fd_pkg.sv
// fd_pkg -- shared definitions for the fd_pipe shift pipeline.
//   WIDTH_MIN/WIDTH_MAX, DEPTH_MIN/DEPTH_MAX : legal parameter limits
//   act_e       : per-edge action, encoded in rising priority order
//   count_width : bits needed to hold an occupancy count of 0..depth
//   sel_width   : bits of the tap-select port (never less than 1)
package fd_pkg;

   localparam int unsigned WIDTH_MIN = 1;
   localparam int unsigned WIDTH_MAX = 32;
   localparam int unsigned DEPTH_MIN = 1;
   localparam int unsigned DEPTH_MAX = 16;

   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_SHIFT = 2'd1,
      ACT_FLUSH = 2'd2,
      ACT_SET   = 2'd3
   } act_e;

   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned sel_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fd_stage.sv
// fd_stage -- one WIDTH-bit pipeline register, updated on the falling edge.
//   ck  : clock (falling edge active)
//   cl  : asynchronous active-low clear to RST_VAL
//   act : action for this edge (hold / shift / flush / set)
//   d   : value loaded on a shift
//   q   : stored value
module fd_stage
   import fd_pkg::*;
#(
   parameter int unsigned        WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic             ck,
   input  logic             cl,
   input  act_e             act,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(negedge ck or negedge cl) begin
      if (!cl) begin
         q <= RST_VAL;
      end else begin
         case (act)
            ACT_SET:   q <= '1;
            ACT_FLUSH: q <= RST_VAL;
            ACT_SHIFT: q <= d;
            default:   q <= q;
         endcase
      end
   end

endmodule

// File: rtl/fd_pipe.sv
// fd_pipe -- DEPTH-stage, WIDTH-bit shift pipeline with occupancy count.
// All state changes on the falling edge of CK; CL clears asynchronously.
//   CK    : clock (falling edge active)       CL    : async active-low reset
//   EN    : shift enable                      D     : data into stage 0
//   SET   : preset all stages to all-ones     FLUSH : clear all stages to RST_VAL
//   SEL   : tap stage index                   Q/nQ  : last stage and its inverse
//   TAP   : selected stage                    COUNT : valid stages, FULL : COUNT==DEPTH
// Build option: define FD_PIPE_TAP_EN to make TAP follow SEL; otherwise TAP
// mirrors Q, SEL is ignored and no tap multiplexer exists.
module fd_pipe
   import fd_pkg::*;
#(
   parameter int unsigned        WIDTH   = 8,
   parameter int unsigned        DEPTH   = 4,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic                           CK,
   input  logic                           CL,
   input  logic                           EN,
   input  logic [WIDTH-1:0]               D,
   input  logic                           SET,
   input  logic                           FLUSH,
   input  logic [sel_width(DEPTH)-1:0]    SEL,
   output logic [WIDTH-1:0]               Q,
   output logic [WIDTH-1:0]               nQ,
   output logic [WIDTH-1:0]               TAP,
   output logic [count_width(DEPTH)-1:0]  COUNT,
   output logic                           FULL
);

   localparam int unsigned   CW        = count_width(DEPTH);
   localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

   act_e             act;
   logic [WIDTH-1:0] stage [DEPTH];

   always_comb begin
      act = ACT_HOLD;
      if (SET)        act = ACT_SET;
      else if (FLUSH) act = ACT_FLUSH;
      else if (EN)    act = ACT_SHIFT;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         fd_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
            .ck (CK), .cl (CL), .act (act), .d (D), .q (stage[i])
         );
      end else begin : g_body
         fd_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
            .ck (CK), .cl (CL), .act (act), .d (stage[i-1]), .q (stage[i])
         );
      end
   end

   always_ff @(negedge CK or negedge CL) begin
      if (!CL) begin
         COUNT <= '0;
      end else begin
         case (act)
            ACT_SET:   COUNT <= COUNT_MAX;
            ACT_FLUSH: COUNT <= '0;
            ACT_SHIFT: if (COUNT != COUNT_MAX) COUNT <= COUNT + 1'b1;
            default:   COUNT <= COUNT;
         endcase
      end
   end

   assign FULL = (COUNT == COUNT_MAX);
   assign Q    = stage[DEPTH-1];
   assign nQ   = ~Q;

`ifdef FD_PIPE_TAP_EN
   // Out-of-range selects fall through to the last stage.
   always_comb begin
      TAP = stage[DEPTH-1];
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (32'(SEL) == i) TAP = stage[i];
      end
   end
`else
   logic sel_unused;
   assign sel_unused = ^SEL;
   assign TAP        = Q;
`endif

endmodule

// File: tb/tb_fd_pipe.sv
module tb_fd_pipe;

   logic       CK = 1'b1;
   logic       CL = 1'b1;
   logic       EN = 1'b0;
   logic       SET = 1'b0;
   logic       FLUSH = 1'b0;
   logic [7:0] D = 8'h00;
   logic       D1 = 1'b0;
   logic [1:0] SEL = 2'd0;
   logic [1:0] SEL3 = 2'd0;
   logic       SEL1 = 1'b0;

   logic [7:0] Q, nQ, TAP, Q3, nQ3, TAP3;
   logic [2:0] COUNT;
   logic [1:0] COUNT3;
   logic       FULL, FULL3;
   logic       Q1, nQ1, TAP1, COUNT1, FULL1;

   int total = 0;
   int bad   = 0;

   always #5 CK = ~CK;

   fd_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
      .CK(CK), .CL(CL), .EN(EN), .D(D), .SET(SET), .FLUSH(FLUSH), .SEL(SEL),
      .Q(Q), .nQ(nQ), .TAP(TAP), .COUNT(COUNT), .FULL(FULL)
   );

   fd_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h5A)) u_dut3 (
      .CK(CK), .CL(CL), .EN(EN), .D(D), .SET(SET), .FLUSH(FLUSH), .SEL(SEL3),
      .Q(Q3), .nQ(nQ3), .TAP(TAP3), .COUNT(COUNT3), .FULL(FULL3)
   );

   fd_pipe #(.WIDTH(1), .DEPTH(1)) u_dut1 (
      .CK(CK), .CL(CL), .EN(EN), .D(D1), .SET(SET), .FLUSH(FLUSH), .SEL(SEL1),
      .Q(Q1), .nQ(nQ1), .TAP(TAP1), .COUNT(COUNT1), .FULL(FULL1)
   );

   task automatic step();
      @(negedge CK);
      #1;
   endtask

   task automatic test_reset();
      #1 CL = 1'b0;
      #3;
      total++; if (Q !== 8'h00) begin bad++; $display("FAIL rst_q got=%h exp=00", Q); end
      total++; if (nQ !== 8'hFF) begin bad++; $display("FAIL rst_nq got=%h exp=ff", nQ); end
      total++; if (TAP !== 8'h00) begin bad++; $display("FAIL rst_tap got=%h exp=00", TAP); end
      total++; if (COUNT !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", COUNT); end
      total++; if (FULL !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", FULL); end
      total++; if (Q3 !== 8'h5A) begin bad++; $display("FAIL rst_q3 got=%h exp=5a", Q3); end
      total++; if (nQ3 !== 8'hA5) begin bad++; $display("FAIL rst_nq3 got=%h exp=a5", nQ3); end
      total++; if (Q1 !== 1'b0 || nQ1 !== 1'b1 || COUNT1 !== 1'b0) begin
         bad++; $display("FAIL rst_d1 got q=%b nq=%b cnt=%b exp q=0 nq=1 cnt=0", Q1, nQ1, COUNT1);
      end
      @(posedge CK);
      #1 CL = 1'b1;
   endtask

   task automatic test_fill();
      EN = 1'b1;
      D = 8'h01; step();
      D = 8'h02; step();
      D = 8'h03; step();
      total++; if (Q !== 8'h00) begin bad++; $display("FAIL fill3_q got=%h exp=00", Q); end
      total++; if (COUNT !== 3'd3 || FULL !== 1'b0) begin
         bad++; $display("FAIL fill3_count got=%0d/%b exp=3/0", COUNT, FULL);
      end
      total++; if (Q3 !== 8'h01 || FULL3 !== 1'b1) begin
         bad++; $display("FAIL fill3_q3 got=%h/%b exp=01/1", Q3, FULL3);
      end
      D = 8'h04; step();
      total++; if (Q !== 8'h01) begin bad++; $display("FAIL fill4_q got=%h exp=01", Q); end
      total++; if (nQ !== 8'hFE) begin bad++; $display("FAIL fill4_nq got=%h exp=fe", nQ); end
      total++; if (COUNT !== 3'd4 || FULL !== 1'b1) begin
         bad++; $display("FAIL fill4_count got=%0d/%b exp=4/1", COUNT, FULL);
      end
      D = 8'h05; step();
      total++; if (Q !== 8'h02 || COUNT !== 3'd4) begin
         bad++; $display("FAIL sat_q got=%h/%0d exp=02/4", Q, COUNT);
      end
      total++; if (Q3 !== 8'h03 || COUNT3 !== 2'd3) begin
         bad++; $display("FAIL sat_q3 got=%h/%0d exp=03/3", Q3, COUNT3);
      end
   endtask

   task automatic test_hold();
      EN = 1'b0;
      D = 8'h77;
      step(); step();
      total++; if (Q !== 8'h02 || COUNT !== 3'd4) begin
         bad++; $display("FAIL hold_q got=%h/%0d exp=02/4", Q, COUNT);
      end
      total++; if (Q3 !== 8'h03) begin bad++; $display("FAIL hold_q3 got=%h exp=03", Q3); end
   endtask

   task automatic test_priority();
      EN = 1'b1; SET = 1'b1; FLUSH = 1'b1; D = 8'h33; SEL = 2'd0;
      step();
      total++; if (Q !== 8'hFF || nQ !== 8'h00 || COUNT !== 3'd4) begin
         bad++; $display("FAIL set_q got=%h/%h/%0d exp=ff/00/4", Q, nQ, COUNT);
      end
`ifdef FD_PIPE_TAP_EN
      total++; if (TAP !== 8'hFF) begin bad++; $display("FAIL set_tap0 got=%h exp=ff", TAP); end
`endif
      SET = 1'b0;
      step();
      total++; if (Q !== 8'h00 || COUNT !== 3'd0 || FULL !== 1'b0) begin
         bad++; $display("FAIL flush_q got=%h/%0d/%b exp=00/0/0", Q, COUNT, FULL);
      end
      total++; if (Q3 !== 8'h5A || COUNT3 !== 2'd0) begin
         bad++; $display("FAIL flush_q3 got=%h/%0d exp=5a/0", Q3, COUNT3);
      end
`ifdef FD_PIPE_TAP_EN
      total++; if (TAP !== 8'h00) begin bad++; $display("FAIL flush_tap0 got=%h exp=00", TAP); end
`endif
      FLUSH = 1'b0;
   endtask

   task automatic test_async_reset();
      EN = 1'b1; SEL = 2'd0;
      D = 8'h11; step();
      D = 8'h22; step();
      total++; if (COUNT !== 3'd2) begin bad++; $display("FAIL mid_count got=%0d exp=2", COUNT); end
      #2 CL = 1'b0;
      #1;
      total++; if (Q !== 8'h00 || COUNT !== 3'd0 || TAP !== 8'h00) begin
         bad++; $display("FAIL async_clr got=%h/%0d/%h exp=00/0/00", Q, COUNT, TAP);
      end
      total++; if (Q3 !== 8'h5A) begin bad++; $display("FAIL async_q3 got=%h exp=5a", Q3); end
      SET = 1'b1;
      step();
      total++; if (Q !== 8'h00 || COUNT !== 3'd0) begin
         bad++; $display("FAIL rst_over_set got=%h/%0d exp=00/0", Q, COUNT);
      end
      SET = 1'b0; CL = 1'b1; D = 8'h99;
      @(posedge CK);
      #1;
      total++; if (Q !== 8'h00 || COUNT !== 3'd0) begin
         bad++; $display("FAIL rise_only got=%h/%0d exp=00/0", Q, COUNT);
      end
      step();
      total++; if (COUNT !== 3'd1 || Q !== 8'h00) begin
         bad++; $display("FAIL post_rst got=%h/%0d exp=00/1", Q, COUNT);
      end
`ifdef FD_PIPE_TAP_EN
      total++; if (TAP !== 8'h99) begin bad++; $display("FAIL post_rst_tap got=%h exp=99", TAP); end
`endif
      D = 8'hAA; step();
      D = 8'hBB; step();
      D = 8'hCC; step();
      total++; if (Q !== 8'h99 || COUNT !== 3'd4) begin
         bad++; $display("FAIL refill got=%h/%0d exp=99/4", Q, COUNT);
      end
   endtask

   task automatic test_tap();
      EN = 1'b1;
      D = 8'h0A; step();
      D = 8'h0B; step();
      D = 8'h0C; step();
      D = 8'h0D; step();
      EN = 1'b0;
      SEL = 2'd0; SEL3 = 2'd3; #1;
`ifdef FD_PIPE_TAP_EN
      total++; if (TAP !== 8'h0D) begin bad++; $display("FAIL tap_sel0 got=%h exp=0d", TAP); end
`else
      total++; if (TAP !== 8'h0A) begin bad++; $display("FAIL tap_eq_q0 got=%h exp=0a", TAP); end
`endif
      total++; if (TAP3 !== 8'h0B) begin bad++; $display("FAIL tap3_oor got=%h exp=0b", TAP3); end
      SEL = 2'd1; SEL3 = 2'd0; #1;
`ifdef FD_PIPE_TAP_EN
      total++; if (TAP !== 8'h0C) begin bad++; $display("FAIL tap_sel1 got=%h exp=0c", TAP); end
      total++; if (TAP3 !== 8'h0D) begin bad++; $display("FAIL tap3_sel0 got=%h exp=0d", TAP3); end
`else
      total++; if (TAP !== 8'h0A) begin bad++; $display("FAIL tap_eq_q1 got=%h exp=0a", TAP); end
      total++; if (TAP3 !== 8'h0B) begin bad++; $display("FAIL tap3_eq_q got=%h exp=0b", TAP3); end
`endif
      SEL = 2'd3; #1;
      total++; if (TAP !== 8'h0A) begin bad++; $display("FAIL tap_sel3 got=%h exp=0a", TAP); end
   endtask

   task automatic test_depth1();
      EN = 1'b0; FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      total++; if (Q1 !== 1'b0 || COUNT1 !== 1'b0) begin
         bad++; $display("FAIL d1_flush got=%b/%b exp=0/0", Q1, COUNT1);
      end
      EN = 1'b1; SEL1 = 1'b1;
      D1 = 1'b1; step();
      total++; if (Q1 !== 1'b1 || nQ1 !== 1'b0 || COUNT1 !== 1'b1 || FULL1 !== 1'b1) begin
         bad++; $display("FAIL d1_one got=%b/%b/%b/%b exp=1/0/1/1", Q1, nQ1, COUNT1, FULL1);
      end
      total++; if (TAP1 !== 1'b1) begin bad++; $display("FAIL d1_tap got=%b exp=1", TAP1); end
      D1 = 1'b0; step();
      total++; if (Q1 !== 1'b0 || nQ1 !== 1'b1 || COUNT1 !== 1'b1) begin
         bad++; $display("FAIL d1_zero got=%b/%b/%b exp=0/1/1", Q1, nQ1, COUNT1);
      end
      D1 = 1'b1; step();
      total++; if (Q1 !== 1'b1 || nQ1 !== 1'b0) begin
         bad++; $display("FAIL d1_again got=%b/%b exp=1/0", Q1, nQ1);
      end
      EN = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_hold();
      test_priority();
      test_async_reset();
      test_tap();
      test_depth1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got=stalled exp=finished");
      $fatal(1);
   end

endmodule
